pipe_latency_probe: RTL and testbench



---
 rtl/probe_if.sv | 28 ++
 rtl/pipe_latency_probe.sv | 121 ++++++++++++
 tb/tb_pipe_latency_probe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/probe_if.sv
// Handshake and data bundle between a pipeline-latency probe and its driver.
// The master drives commands and the two monitored nibble streams; the slave reports results.
interface probe_if #(
    parameter int W     = 4,
    parameter int LW    = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [W-1:0]     din;
    logic [W-1:0]     dout;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [LW-1:0]    latency;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output start, stop, din, dout,
        input  busy, done, timeout, latency, err, err_cnt
    );

    modport slave (
        input  start, stop, din, dout,
        output busy, done, timeout, latency, err, err_cnt
    );
endinterface

// File: rtl/pipe_latency_probe.sv
// Measures an upstream pipeline's latency with a marker value, then optionally checks dout tracks din.
// Define PROBE_CHECK_EN to compile in the post-measurement CHECK state and mismatch counter.
module pipe_latency_probe #(
    parameter int W       = 4,
    parameter int MAX_LAT = 7,
    parameter int LW      = $clog2(MAX_LAT + 1),
    parameter int CNT_W   = 8
) (
    input  logic   clk,
    input  logic   rst,
    probe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t        state_q;
    logic [W-1:0]  marker_q;
    logic [LW-1:0] n_q;
    logic [LW-1:0] k;
    logic          busy_q;
    logic          done_q;
    logic          timeout_q;
    logic [LW-1:0] latency_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        k = n_q + LW'(1);
    end

`ifdef PROBE_CHECK_EN
    logic [W-1:0]     hist_q [MAX_LAT];
    logic [W-1:0]     expected;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_comb begin
        expected = hist_q[latency_q - LW'(1)];
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err     = 1'b0;
    assign bus.err_cnt = {CNT_W{1'b0}};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            marker_q  <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            latency_q <= '0;
`ifdef PROBE_CHECK_EN
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            // NOTE: the history is cleared on reset so a fresh CHECK never compares stale data.
            for (int i = 0; i < MAX_LAT; i++) hist_q[i] <= '0;
`endif
        end else begin
`ifdef PROBE_CHECK_EN
            hist_q[0] <= bus.din;
            for (int i = 1; i < MAX_LAT; i++) hist_q[i] <= hist_q[i-1];
`endif
            done_q    <= 1'b0;
            timeout_q <= 1'b0;

            if (bus.stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (bus.start) begin
                marker_q  <= bus.din;
                n_q       <= '0;
                latency_q <= '0;
`ifdef PROBE_CHECK_EN
                err_q     <= 1'b0;
                err_cnt_q <= '0;
`endif
                state_q   <= WAIT;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    WAIT: begin
                        n_q <= k;
                        if (bus.dout == marker_q) begin
                            latency_q <= k;
                            done_q    <= 1'b1;
`ifdef PROBE_CHECK_EN
                            state_q   <= CHECK;
`else
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
`endif
                        end else if (k == LW'(MAX_LAT)) begin
                            timeout_q <= 1'b1;
                            latency_q <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
`ifdef PROBE_CHECK_EN
                    CHECK: begin
                        if (bus.dout != expected) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.latency = latency_q;
endmodule

// File: tb/tb_pipe_latency_probe.sv
// Directed bench for pipe_latency_probe driving a bench-side 1- or 2-register pipeline model.
// CHECK-state scenarios run only when PROBE_CHECK_EN is defined.
module tb_pipe_latency_probe;
`ifdef PROBE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] p1, p2;
    logic [1:0] sel;
    logic [3:0] corrupt;
    int         n_cmp = 0;
    int         n_bad = 0;

    probe_if #(.W(4), .LW(3), .CNT_W(8)) ifc ();

    pipe_latency_probe dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Upstream pipeline under observation: sel picks constant 0, one register, or two registers.
    always @(posedge clk) begin
        p1 <= ifc.din;
        p2 <= p1;
    end
    assign ifc.dout = ((sel == 2'd1) ? p1 : (sel == 2'd2) ? p2 : 4'h0) ^ corrupt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two-stage measurement with marker 9 preceded by zeros; latency must come out as 2.
    task automatic measure2(input string tag);
        ifc.din = 4'h0;
        tick();
        tick();
        ifc.din   = 4'h9;
        ifc.start = 1'b1;
        tick();
        check({tag, "_start_lat"}, ifc.latency, 0);
        check({tag, "_start_cnt"}, ifc.err_cnt, 0);
        ifc.start = 1'b0;
        ifc.din   = 4'h0;
        tick();
        check({tag, "_k1_done"}, ifc.done, 0);
        tick();
        check({tag, "_k2_done"}, ifc.done, 1);
        check({tag, "_k2_lat"}, ifc.latency, 2);
    endtask

    initial begin
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        ifc.din   = 4'h0;
        sel       = 2'd1;
        corrupt   = 4'h0;
        tick();
        tick();
        check("reset_outputs", {ifc.busy, ifc.done, ifc.timeout, ifc.latency, ifc.err, ifc.err_cnt}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", ifc.busy, 0);

        // Single register: marker 3, found one edge later.
        ifc.din   = 4'h3;
        ifc.start = 1'b1;
        tick();
        check("t1_busy_rise", ifc.busy, 1);
        check("t1_no_done_on_start", ifc.done, 0);
        ifc.start = 1'b0;
        ifc.din   = 4'h7;
        tick();
        check("t1_done", ifc.done, 1);
        check("t1_latency", ifc.latency, 1);
        check("t1_busy", ifc.busy, 32'(CHECK_EN));
        ifc.din = 4'hC;
        tick();
        check("t1_done_pulse", ifc.done, 0);
        check("t1_latency_held", ifc.latency, 1);
        check("t1_err", ifc.err, 0);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        check("t1_stop_busy", ifc.busy, 0);

        // Two registers: din 3,7,F,A,2 with start on 7.
        sel     = 2'd2;
        ifc.din = 4'h0;
        tick();
        tick();
        ifc.din = 4'h3;
        tick();
        ifc.din   = 4'h7;
        ifc.start = 1'b1;
        tick();
        check("t2_start_lat", ifc.latency, 0);
        ifc.start = 1'b0;
        ifc.din   = 4'hF;
        tick();
        check("t2_k1_done", ifc.done, 0);
        ifc.din = 4'hA;
        tick();
        check("t2_done", ifc.done, 1);
        check("t2_latency", ifc.latency, 2);
        ifc.din = 4'h2;
        tick();
        check("t2_done_pulse", ifc.done, 0);

        if (CHECK_EN) begin
            for (int i = 0; i < 20; i++) begin
                ifc.din = 4'($urandom_range(0, 15));
                tick();
            end
            check("chk_clean_cnt", ifc.err_cnt, 0);
            check("chk_clean_err", ifc.err, 0);
            for (int i = 0; i < 3; i++) begin
                corrupt = 4'hF;
                ifc.din = 4'($urandom_range(0, 15));
                tick();
                check("chk_err_cnt_step", ifc.err_cnt, i + 1);
                corrupt = 4'h0;
                tick();
            end
            check("chk_err", ifc.err, 1);
            check("chk_err_cnt3", ifc.err_cnt, 3);
            ifc.stop = 1'b1;
            tick();
            ifc.stop = 1'b0;
            corrupt  = 4'hF;
            tick();
            corrupt = 4'h0;
            check("stop_busy", ifc.busy, 0);
            check("stop_lat_held", ifc.latency, 2);
            check("stop_err_held", ifc.err, 1);
            check("stop_cnt_held", ifc.err_cnt, 3);

            measure2("sat");
            corrupt = 4'hF;
            for (int i = 0; i < 300; i++) begin
                ifc.din = 4'($urandom_range(0, 15));
                tick();
            end
            corrupt = 4'h0;
            check("sat_cnt", ifc.err_cnt, 255);

            measure2("restart");
            check("restart_err", ifc.err, 0);
            ifc.stop = 1'b1;
            tick();
            ifc.stop = 1'b0;
        end

        // Stop in WAIT wins over a match on the same edge; no pulse, latency held.
        sel     = 2'd1;
        ifc.din = 4'h0;
        tick();
        ifc.din   = 4'h6;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.stop  = 1'b1;
        ifc.din   = 4'h0;
        tick();
        ifc.stop = 1'b0;
        check("stopw_done", ifc.done, 0);
        check("stopw_busy", ifc.busy, 0);
        check("stopw_lat", ifc.latency, 0);

        // dout stuck at 0, marker 5: timeout after edge 7.
        sel       = 2'd0;
        ifc.din   = 4'h5;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.din   = 4'hB;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("to_early", {ifc.busy, ifc.timeout}, 2'b10);
        end
        tick();
        check("to_pulse", ifc.timeout, 1);
        check("to_done", ifc.done, 0);
        check("to_lat", ifc.latency, 0);
        check("to_busy", ifc.busy, 0);
        tick();
        check("to_pulse_end", ifc.timeout, 0);

        // Reset in WAIT at k=1 where a match would otherwise occur.
        sel     = 2'd1;
        ifc.din = 4'h0;
        tick();
        ifc.din   = 4'h4;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        rst       = 1'b1;
        tick();
        check("rst_wait_outputs", {ifc.busy, ifc.done, ifc.timeout, ifc.latency, ifc.err, ifc.err_cnt}, 0);
        rst = 1'b0;
        tick();
        check("rst_wait_idle", {ifc.busy, ifc.done}, 0);

        // start and stop together in IDLE: stays IDLE.
        ifc.start = 1'b1;
        ifc.stop  = 1'b1;
        ifc.din   = 4'hD;
        tick();
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        check("startstop_busy", ifc.busy, 0);
        tick();
        check("startstop_done", {ifc.busy, ifc.done, ifc.timeout}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
